sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO. It replaces the fixed 4-deep, externally-RAM-backed FIFO with self-contained storage and generic width and depth. It adds an occupancy count, programmable almost-full and almost-empty flags, optional first-word-fall-through (FWFT) read mode, sticky overflow/underflow error flags, and a synchronous flush. It sits between any single-clock producer and consumer in the datapath.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries. Power of two, ≥2. ADDR_W = log2(DEPTH), derived internally.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH. Range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH. Range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = registered read; 1 = first-word-fall-through.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request (pop).
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data holds a valid popped/head word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- Storage: DEPTH×WIDTH register array. Storage is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits and wrap modulo 2·DEPTH. The low ADDR_W bits index the array. Wrap from DEPTH-1 to 0 is natural; no special case.
- Write acceptance: wr_acc = wr_en & ~full. On acceptance, mem[wr_ptr] ← wr_data and wr_ptr +1.
- Read acceptance: rd_acc = rd_en & ~empty. On acceptance, rd_ptr +1.
- Count update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged on both or neither.
  - count is registered; all status flags derive from registered state.
- Simultaneous read and write:
  - When full: the read is accepted, the write is rejected, and overflow sets.
  - When empty: the write is accepted, the read is rejected, and underflow sets.
  - Otherwise both are accepted and count is unchanged.
- Errors:
  - overflow sets on wr_en & full. underflow sets on rd_en & empty.
  - Both hold until clr_err or reset.
  - If a set event and clr_err occur in the same cycle, set wins.
- Flush:
  - Has priority over wr_en and rd_en in the same cycle.
  - Zeroes pointers and count and drops rd_valid.
  - Does not clear error flags and does not set them.
- FWFT=0: on rd_acc, rd_data ← mem[rd_ptr] and rd_valid ← 1 on the next edge. Otherwise rd_valid ← 0 and rd_data holds its previous value.
- FWFT=1: rd_data = mem[rd_ptr[ADDR_W-1:0]] and rd_valid = ~empty. rd_en acknowledges (pops) the displayed word.
- rd_data is don't-care whenever rd_valid = 0.

## Timing
- Reset values:
  - count = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (for AF_THRESH ≥ 1).
  - rd_valid = 0, rd_data = 0, overflow = 0, underflow = 0.
  - Pointers are 0.
- Reset mid-operation discards all contents immediately (asynchronous). The first write may be accepted on the first rising edge after rst_n deasserts.
- Write to empty: empty falls and count = 1 one cycle after the accepting edge. In FWFT mode, rd_valid and the word appear in that same cycle.
- Read latency, FWFT=0: rd_data/rd_valid are valid one cycle after the edge where rd_acc = 1.
- Back-to-back: one write and one read per cycle sustained, with no bubbles.
- Full rises on the edge of the DEPTH-th net write. The same-cycle wr_en after that edge is rejected.

## Test plan
- DEPTH=4, WIDTH=8, FWFT=0. Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → count 1..4, full = 1 after the 4th edge, almost_full = 1 at count ≥ 2. A 5th write of 0x55 → rejected, overflow = 1, count stays 4.
- Continue from full: rd_en for 4 cycles → rd_data = 0x11, 0x22, 0x33, 0x44, each with rd_valid one cycle after its request. Then empty = 1. A 5th rd_en → underflow = 1, rd_valid = 0.
- Wrap-around: 10 cycles of simultaneous write/read at count = 2 → count stays 2 and data order is preserved across pointer wrap.
- Full + simultaneous rd/wr: the read returns the oldest word, the write is rejected, count goes 4→3, overflow = 1. Then clr_err → both error flags are 0 next cycle.
- FWFT=1: write 0xA5 to empty → next cycle rd_valid = 1 and rd_data = 0xA5 with no rd_en. rd_en → rd_valid = 0 next cycle.
- Flush with 3 entries plus wr_en in the same cycle → count = 0, empty = 1, write discarded, error flags unchanged. Async reset asserted mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with self-contained register storage.
// It provides occupancy and threshold flags, sticky error flags, synchronous flush and an optional FWFT read mode.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [ADDR_W:0]   ptr_t;
    typedef logic [ADDR_W-1:0] idx_t;

    localparam ptr_t ONE     = ptr_t'(1);
    localparam ptr_t DEPTH_C = ptr_t'(DEPTH);
    localparam ptr_t AF_C    = ptr_t'(AF_THRESH);
    localparam ptr_t AE_C    = ptr_t'(AE_THRESH);

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             count_q,  count_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic wr_acc;
    logic rd_acc;
    idx_t wr_idx;
    idx_t rd_idx;

    // Every flag is a decode of the registered count, so none has a combinational path from the inputs.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;
    assign wr_idx = wr_ptr_q[ADDR_W-1:0];
    assign rd_idx = rd_ptr_q[ADDR_W-1:0];

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // A set event in the same cycle as clr_err wins; flush neither sets nor clears the flags.
    always_comb begin
        overflow_d  = (~flush & wr_en & full)  | (overflow_q  & ~clr_err);
        underflow_d = (~flush & rd_en & empty) | (underflow_q & ~clr_err);
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_acc && !flush) mem_d[wr_idx] = wr_data;
    end

    // NOTE: sequential state is assigned with non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset. The pointers and count define which entries are valid, so a reset would only cost area.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] rd_data_q, rd_data_d;
            logic             rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
                if (!flush && rd_acc) begin
                    rd_data_d  = mem_q[rd_idx];
                    rd_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft_read
            // The head word is shown directly. It is gated to zero while empty, so reset presents a clean value.
            assign rd_valid = ~empty;
            assign rd_data  = empty ? '0 : mem_q[rd_idx];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param using two 4-deep, 8-bit instances: one registered-read and one FWFT.
// Every expected value below is hand-derived from the FIFO behaviour.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;

    logic       flush0, wr_en0, rd_en0, clr_err0;
    logic [7:0] wr_data0, rd_data0;
    logic       rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [2:0] count0;

    logic       flush1, wr_en1, rd_en1, clr_err1;
    logic [7:0] wr_data1, rd_data1;
    logic       rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [2:0] count1;

    int n_cmp  = 0;
    int n_fail = 0;

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .wr_en(wr_en0), .wr_data(wr_data0),
        .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0),
        .underflow(unf0), .clr_err(clr_err0)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .wr_en(wr_en1), .wr_data(wr_data1),
        .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1),
        .underflow(unf1), .clr_err(clr_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset0(input string tag);
        check({tag, " count"},     32'(count0),    0);
        check({tag, " empty"},     32'(empty0),    1);
        check({tag, " ae"},        32'(ae0),       1);
        check({tag, " full"},      32'(full0),     0);
        check({tag, " af"},        32'(af0),       0);
        check({tag, " rd_valid"},  32'(rd_valid0), 0);
        check({tag, " rd_data"},   32'(rd_data0),  0);
        check({tag, " overflow"},  32'(ovf0),      0);
        check({tag, " underflow"}, 32'(unf0),      0);
    endtask

    initial begin
        rst_n  = 1'b1;
        flush0 = 0; wr_en0 = 0; rd_en0 = 0; clr_err0 = 0; wr_data0 = 8'h00;
        flush1 = 0; wr_en1 = 0; rd_en1 = 0; clr_err1 = 0; wr_data1 = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset0("reset");
        check("reset fwft rd_valid", 32'(rd_valid1), 0);
        check("reset fwft rd_data",  32'(rd_data1),  0);
        check("reset fwft empty",    32'(empty1),    1);
        @(negedge clk) rst_n = 1'b1;

        // Fill: 0x11..0x44
        wr_en0 = 1; wr_data0 = 8'h11; tick();
        check("fill1 count", 32'(count0), 1); check("fill1 af", 32'(af0), 0);
        check("fill1 ae", 32'(ae0), 1);       check("fill1 empty", 32'(empty0), 0);
        wr_data0 = 8'h22; tick();
        check("fill2 count", 32'(count0), 2); check("fill2 af", 32'(af0), 1);
        check("fill2 ae", 32'(ae0), 0);
        wr_data0 = 8'h33; tick();
        check("fill3 count", 32'(count0), 3); check("fill3 full", 32'(full0), 0);
        wr_data0 = 8'h44; tick();
        check("fill4 count", 32'(count0), 4); check("fill4 full", 32'(full0), 1);
        check("fill4 ovf", 32'(ovf0), 0);
        wr_data0 = 8'h55; tick();
        check("over count", 32'(count0), 4); check("over ovf", 32'(ovf0), 1);
        wr_en0 = 0;

        // Drain, one cycle of read latency
        rd_en0 = 1; tick();
        check("rd1 valid", 32'(rd_valid0), 1); check("rd1 data", 32'(rd_data0), 32'h11);
        check("rd1 count", 32'(count0), 3);    check("rd1 full", 32'(full0), 0);
        tick();
        check("rd2 valid", 32'(rd_valid0), 1); check("rd2 data", 32'(rd_data0), 32'h22);
        tick();
        check("rd3 valid", 32'(rd_valid0), 1); check("rd3 data", 32'(rd_data0), 32'h33);
        tick();
        check("rd4 valid", 32'(rd_valid0), 1); check("rd4 data", 32'(rd_data0), 32'h44);
        check("rd4 empty", 32'(empty0), 1);
        tick();
        check("under unf", 32'(unf0), 1);    check("under valid", 32'(rd_valid0), 0);
        check("under ovf sticky", 32'(ovf0), 1);
        rd_en0 = 0; clr_err0 = 1; tick();
        check("clr1 ovf", 32'(ovf0), 0); check("clr1 unf", 32'(unf0), 0);
        clr_err0 = 0;

        // Wrap-around at count 2
        wr_en0 = 1; wr_data0 = 8'hA0; tick();
        wr_data0 = 8'hA1; tick();
        rd_en0 = 1;
        for (int i = 0; i < 10; i++) begin
            wr_data0 = 8'(8'hA2 + i); tick();
            check($sformatf("wrap%0d data", i),  32'(rd_data0),  32'(8'hA0 + i));
            check($sformatf("wrap%0d valid", i), 32'(rd_valid0), 1);
            check($sformatf("wrap%0d count", i), 32'(count0),    2);
        end
        rd_en0 = 0;

        // Full with simultaneous read and write
        wr_data0 = 8'hB0; tick();
        wr_data0 = 8'hB1; tick();
        check("fullrw pre full", 32'(full0), 1);
        rd_en0 = 1; wr_data0 = 8'hCC; tick();
        check("fullrw data", 32'(rd_data0), 32'hAA); check("fullrw count", 32'(count0), 3);
        check("fullrw ovf", 32'(ovf0), 1);           check("fullrw unf", 32'(unf0), 0);
        wr_en0 = 0; rd_en0 = 0; clr_err0 = 1; tick();
        check("clr2 ovf", 32'(ovf0), 0); check("clr2 valid", 32'(rd_valid0), 0);
        clr_err0 = 0; rd_en0 = 1; tick();
        check("post1 data", 32'(rd_data0), 32'hAB);
        tick();
        check("post2 data", 32'(rd_data0), 32'hB0);
        tick();
        check("post3 data", 32'(rd_data0), 32'hB1); check("post3 empty", 32'(empty0), 1);

        // Flush with a pending write, underflow already set
        tick();
        check("pre-flush unf", 32'(unf0), 1);
        rd_en0 = 0; wr_en0 = 1;
        wr_data0 = 8'h31; tick(); wr_data0 = 8'h32; tick(); wr_data0 = 8'h33; tick();
        check("pre-flush count", 32'(count0), 3);
        flush0 = 1; rd_en0 = 1; wr_data0 = 8'h99; tick();
        check("flush count", 32'(count0), 0);    check("flush empty", 32'(empty0), 1);
        check("flush valid", 32'(rd_valid0), 0); check("flush unf", 32'(unf0), 1);
        check("flush ovf", 32'(ovf0), 0);
        flush0 = 0; rd_en0 = 0; wr_en0 = 0; tick();
        check("flush drop", 32'(count0), 0);
        wr_en0 = 1; wr_data0 = 8'h41; tick();
        check("pf wr count", 32'(count0), 1);
        wr_en0 = 0; rd_en0 = 1; tick();
        check("pf rd data", 32'(rd_data0), 32'h41); check("pf rd valid", 32'(rd_valid0), 1);
        rd_en0 = 0;

        // Asynchronous reset mid-stream
        wr_en0 = 1; wr_data0 = 8'h51; tick(); wr_data0 = 8'h52; tick();
        rd_en0 = 1; wr_data0 = 8'h53; tick();
        check("mid valid", 32'(rd_valid0), 1); check("mid count", 32'(count0), 2);
        wr_en0 = 0; rd_en0 = 0;
        #2 rst_n = 1'b0;
        #1;
        check_reset0("async");
        @(negedge clk) rst_n = 1'b1;
        wr_en0 = 1; wr_data0 = 8'h61; tick();
        check("first wr count", 32'(count0), 1); check("first wr empty", 32'(empty0), 0);
        wr_en0 = 0;

        // FWFT instance
        wr_en1 = 1; wr_data1 = 8'hA5; tick();
        wr_en1 = 0;
        check("fwft valid", 32'(rd_valid1), 1); check("fwft data", 32'(rd_data1), 32'hA5);
        check("fwft count", 32'(count1), 1);
        tick();
        check("fwft hold", 32'(rd_data1), 32'hA5); check("fwft hold valid", 32'(rd_valid1), 1);
        rd_en1 = 1; tick();
        rd_en1 = 0;
        check("fwft pop valid", 32'(rd_valid1), 0); check("fwft pop empty", 32'(empty1), 1);
        wr_en1 = 1; wr_data1 = 8'h01; tick(); wr_data1 = 8'h02; tick();
        check("fwft head1", 32'(rd_data1), 32'h01); check("fwft cnt2", 32'(count1), 2);
        rd_en1 = 1; wr_data1 = 8'h03; tick();
        check("fwft head2", 32'(rd_data1), 32'h02); check("fwft cnt2b", 32'(count1), 2);
        wr_en1 = 0; tick();
        check("fwft head3", 32'(rd_data1), 32'h03); check("fwft cnt1", 32'(count1), 1);
        rd_en1 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
